bus_interconnect: RTL and testbench

Parametrised, registered address decoder and response multiplexer between the CPU data-bus master and N memory-mapped slaves (RAM, GPIO, future peripherals). Each slave owns a base/mask address window. The block:
- raises one chip enable for the selected slave;
- waits for that slave's ready;
- returns read data with a one-cycle ready pulse.

Accesses to unmapped addresses, and accesses a slave never answers, complete with an error response instead of hanging the core.

---
 rtl/bus_interconnect.sv | 170 +++++++++++++++++
 tb/tb_bus_interconnect.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_interconnect.sv
`default_nettype none
// ============================================================================
//  Module      : bus_interconnect
//  Description : Registered address decoder and response multiplexer between
//                the CPU data-bus master and N_SLAVES memory-mapped slaves.
//                Each slave owns a base/mask window; unmapped accesses return
//                an error response. Optional macro BUS_TIMEOUT_EN adds a
//                watchdog that errors out accesses a slave never answers.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_interconnect #(
  parameter int                     N_SLAVES   = 2,
  parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = {32'h4010_0000, 32'h1000_0000},
  parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = {32'hFFFF_0000, 32'hFF00_0000},
  parameter int                     TIMEOUT    = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              bus_addr,
  input  logic                     bus_re,
  input  logic [3:0]               bus_we,
  output logic [31:0]              bus_rdata,
  output logic                     bus_ready,
  output logic                     bus_err,
  output logic [N_SLAVES-1:0]      slv_ce,
  input  logic [N_SLAVES-1:0]      slv_ready,
  input  logic [N_SLAVES*32-1:0]   slv_rdata
);

  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t               state;
  logic [SEL_W-1:0]     sel;
  logic                 is_read;
  logic                 req;
  logic [N_SLAVES-1:0]  match;
  logic                 hit;
  logic [SEL_W-1:0]     hit_idx;
  logic [N_SLAVES-1:0]  hit_dec;
  logic                 sel_ready;
  logic [31:0]          sel_rdata;

  assign req = bus_re | (|bus_we);

  // Per-window address comparison
  generate
    for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_match
      assign match[gi] =
        ((bus_addr & SLAVE_MASK[32*gi +: 32]) == SLAVE_BASE[32*gi +: 32]);
    end
  endgenerate

  // Priority pick of the matching window: scanning downward lets the lowest index win
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = i[SEL_W-1:0];
      end
    end
  end

  // One-hot chip-enable pattern for the decoded slave
  always_comb begin
    hit_dec = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      hit_dec[i] = (hit_idx == i[SEL_W-1:0]);
    end
  end

  // Ready and read-data multiplexing from the latched selection
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel == i[SEL_W-1:0]) begin
        sel_ready = slv_ready[i];
        sel_rdata = slv_rdata[32*i +: 32];
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt;
`else
  // TIMEOUT is intentionally unused when the watchdog is compiled out
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
`endif

  // Access sequencer: decode, wait for the slave, produce a one-cycle response
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      slv_ce    <= '0;
      bus_ready <= 1'b0;
      bus_err   <= 1'b0;
      bus_rdata <= '0;
      sel       <= '0;
      is_read   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            if (hit) begin
              sel     <= hit_idx;
              is_read <= bus_re;
              slv_ce  <= hit_dec;
`ifdef BUS_TIMEOUT_EN
              cnt     <= '0;
`endif
              state   <= S_ACCESS;
            end else begin
              bus_err   <= 1'b1;
              bus_rdata <= '0;
              bus_ready <= 1'b1;
              state     <= S_RESP;
            end
          end
        end
        S_ACCESS: begin
          // Ready takes priority over an expiring watchdog
          if (sel_ready) begin
            bus_rdata <= is_read ? sel_rdata : 32'h0;
            bus_err   <= 1'b0;
            bus_ready <= 1'b1;
            slv_ce    <= '0;
            state     <= S_RESP;
          end
`ifdef BUS_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            bus_rdata <= '0;
            bus_err   <= 1'b1;
            bus_ready <= 1'b1;
            slv_ce    <= '0;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        S_RESP: begin
          bus_ready <= 1'b0;
          bus_err   <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          slv_ce    <= '0;
          bus_ready <= 1'b0;
          bus_err   <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_interconnect.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_interconnect
//  Description : Scoreboard bench for bus_interconnect. Stimulus pushes the
//                expected response (error, data, latency, enable cycles) into
//                a queue; a monitor pops and compares on every bus_ready.
//                Honours BUS_TIMEOUT_EN when the design is built with it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_interconnect;

  localparam int TO = 4;
`ifdef BUS_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  // Address map of the main instance, as a plain table
  localparam logic [31:0] BASES [2] = '{32'h1000_0000, 32'h4010_0000};
  localparam logic [31:0] MASKS [2] = '{32'hFF00_0000, 32'hFFFF_0000};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus_addr = '0;
  logic        bus_re = 1'b0;
  logic [3:0]  bus_we = '0;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        bus_err;
  logic [1:0]  slv_ce;
  logic [1:0]  slv_ready;
  logic [63:0] slv_rdata = '0;

  logic [31:0] ovl_rdata;
  logic        ovl_ready;
  logic        ovl_err;
  logic [1:0]  ovl_ce;

  int          wait_n = 0;
  int          ce_cnt = 0;
  logic [1:0]  noise = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_interconnect #(.N_SLAVES(2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_re(bus_re), .bus_we(bus_we),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .bus_err(bus_err),
    .slv_ce(slv_ce), .slv_ready(slv_ready), .slv_rdata(slv_rdata)
  );

  // Overlapping windows: both at 0x1000_0000, slave 0 is the wider one
  bus_interconnect #(
    .N_SLAVES(2),
    .SLAVE_BASE({32'h1000_0000, 32'h1000_0000}),
    .SLAVE_MASK({32'hFF00_0000, 32'hF000_0000}),
    .TIMEOUT(TO)
  ) ovl (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_re(bus_re), .bus_we(bus_we),
    .bus_rdata(ovl_rdata), .bus_ready(ovl_ready), .bus_err(ovl_err),
    .slv_ce(ovl_ce), .slv_ready(ovl_ce), .slv_rdata(64'h1111_1111_2222_2222)
  );

  // Behavioural slave: selected slave answers after wait_n enable cycles;
  // unselected slaves drive random ready noise
  always @(posedge clk) ce_cnt <= (!rst && (|slv_ce)) ? ce_cnt + 1 : 0;
  always_comb begin
    slv_ready = '0;
    for (int i = 0; i < 2; i++)
      slv_ready[i] = slv_ce[i] ? (ce_cnt == wait_n) : noise[i];
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          ce_cycles;
  } exp_t;

  exp_t        q[$];
  logic [1:0]  exp_ce = '0;
  int          req_cyc = 0;

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 2; i++)
      if ((a & MASKS[i]) == BASES[i]) return i;
    return -1;
  endfunction

  // Monitor: compares every completion and every enable cycle
  int          ce_cyc = 0;
  logic        prev_ready = 1'b0;
  logic [31:0] last_rdata = '0;
  always @(negedge clk) begin
    if (rst) begin
      ce_cyc = 0;
      prev_ready = 1'b0;
    end else begin
      if (prev_ready) begin
        checks++;
        if (bus_ready || bus_err || bus_rdata !== last_rdata) begin
          errors++;
          $display("FAIL after_pulse: ready=%0b err=%0b rdata=%h, required 0 0 %h",
                   bus_ready, bus_err, bus_rdata, last_rdata);
        end
      end
      if (slv_ce != 2'b00) begin
        ce_cyc++;
        checks++;
        if (slv_ce !== exp_ce) begin
          errors++;
          $display("FAIL slv_ce: got %b, required %b", slv_ce, exp_ce);
        end
      end
      if (bus_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready: got a response, required none");
        end else begin
          exp_t e;
          e = q.pop_front();
          if (bus_err !== e.err || bus_rdata !== e.rdata) begin
            errors++;
            $display("FAIL response: err=%0b rdata=%h, required err=%0b rdata=%h",
                     bus_err, bus_rdata, e.err, e.rdata);
          end
          checks++;
          if (cyc - req_cyc + 1 != e.lat) begin
            errors++;
            $display("FAIL latency: got %0d, required %0d", cyc - req_cyc + 1, e.lat);
          end
          checks++;
          if (ce_cyc != e.ce_cycles) begin
            errors++;
            $display("FAIL ce_cycles: got %0d, required %0d", ce_cyc, e.ce_cycles);
          end
        end
        ce_cyc = 0;
        last_rdata = bus_rdata;
      end
      prev_ready = bus_ready;
    end
  end

  // Issue one access (called at a negedge) and wait for its completion
  task automatic do_access(input logic [31:0] addr, input logic rd,
                           input logic [3:0] we, input int wt,
                           input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    int   idx;
    bit   done;
    idx = decode(addr);
    slv_rdata = {d1, d0};
    wait_n = wt;
    noise = 2'($urandom_range(0, 3));
    if (idx < 0) begin
      e.err = 1'b1; e.rdata = 32'h0; e.lat = 1; e.ce_cycles = 0;
      exp_ce = 2'b00;
    end else begin
      exp_ce = (idx == 0) ? 2'b01 : 2'b10;
      if (TO_ON && wt > TO - 1) begin
        e.err = 1'b1; e.rdata = 32'h0; e.lat = TO + 1; e.ce_cycles = TO;
      end else begin
        e.err = 1'b0;
        e.rdata = rd ? ((idx == 0) ? d0 : d1) : 32'h0;
        e.lat = wt + 2;
        e.ce_cycles = wt + 1;
      end
    end
    q.push_back(e);
    req_cyc = cyc + 1;
    bus_addr = addr;
    bus_re = rd;
    bus_we = rd ? 4'b0000 : we;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (bus_ready) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no bus_ready, required one");
      q.delete();
    end
    bus_re = 1'b0;
    bus_we = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    checks++;
    if (slv_ce !== 2'b00 || bus_ready !== 1'b0 || bus_err !== 1'b0 || bus_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ce=%b ready=%0b err=%0b rdata=%h, required all 0",
               slv_ce, bus_ready, bus_err, bus_rdata);
    end
    rst = 1'b0;
    @(negedge clk);

    // Overlapping windows resolve to the lowest index
    fork
      do_access(32'h1000_0000, 1'b1, 4'h0, 0, 32'hCAFE_0001, 32'h0);
      begin
        @(negedge clk);
        checks++;
        if (ovl_ce !== 2'b01) begin
          errors++;
          $display("FAIL overlap_ce: got %b, required 01", ovl_ce);
        end
      end
    join

    // Directed cases
    do_access(32'h1000_0004, 1'b1, 4'h0, 0, 32'hDEAD_BEEF, 32'h1234_5678);
    do_access(32'h4010_0010, 1'b0, 4'b0011, 3, 32'hAAAA_AAAA, 32'h5555_5555);
    do_access(32'h2000_0000, 1'b1, 4'h0, 0, 32'h1, 32'h2);
    do_access(32'h4011_0000, 1'b0, 4'b1000, 0, 32'h1, 32'h2);
    do_access(32'h0FFF_FFFF, 1'b1, 4'h0, 0, 32'h1, 32'h2);
    do_access(32'h10FF_FFFC, 1'b1, 4'h0, 5, 32'h0BAD_F00D, 32'h2);
    if (TO_ON) begin
      do_access(32'h1000_0000, 1'b1, 4'h0, 255, 32'h9999_9999, 32'h0);
      do_access(32'h1000_0000, 1'b1, 4'h0, TO - 1, 32'h7777_7777, 32'h0);
    end

    // Reset during ACCESS abandons the access
    slv_rdata = 64'h0;
    wait_n = 6;
    noise = 2'b00;
    exp_ce = 2'b01;
    bus_addr = 32'h1000_0100;
    bus_re = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (slv_ce !== 2'b00 || bus_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort: ce=%b ready=%0b, required 00 0", slv_ce, bus_ready);
    end
    bus_re = 1'b0;
    rst = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (bus_ready) seen = 1'b1;
      end
      checks++;
      if (seen) begin
        errors++;
        $display("FAIL rst_no_pulse: got bus_ready after abort, required none");
      end
    end
    do_access(32'h1000_0100, 1'b1, 4'h0, 1, 32'h0F0F_0F0F, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      logic        rd;
      int          wt;
      case ($urandom_range(0, 4))
        0: a = {8'h10, 24'($urandom)};
        1: a = {16'h4010, 16'($urandom)};
        2: a = $urandom;
        3: a = {8'h40, 24'($urandom)};
        default: a = {4'h1, 28'($urandom)};
      endcase
      rd = 1'($urandom_range(0, 1));
      wt = TO_ON ? $urandom_range(0, 7) : $urandom_range(0, 5);
      do_access(a, rd, 4'($urandom_range(1, 15)), wt, $urandom, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
